// File: rtl/evm_pkg.sv
// evm_pkg: shared ballot-unit state encoding and default timing parameters
package evm_pkg;
  localparam int DEF_DEBOUNCE_CYCLES = 8;
  localparam int DEF_PULSE_LEN       = 4;
  localparam int DEF_LOCKOUT_CYCLES  = 20;
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_EMIT,
    ST_LOCKOUT
  } state_t;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchronizer followed by a counting debouncer with a rise pulse
module btn_debounce
  import evm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] D_END = CW'(DEBOUNCE_CYCLES - 1);
  logic [1:0]    r_sync;
  logic          r_level;
  logic          r_rise;
  logic [CW-1:0] r_cnt;
  logic          w_diff;
  logic          w_flip;
  assign w_diff = r_sync[1] != r_level;
  assign w_flip = w_diff && (r_cnt == D_END);
  assign level  = r_level;
  assign rise   = r_rise;
  // Accept a level change only after the synchronized input has disagreed for the full window
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync  <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync  <= {r_sync[0], raw};
      r_rise  <= w_flip && !r_level;
      r_level <= w_flip ? !r_level : r_level;
      r_cnt   <= (w_diff && !w_flip) ? r_cnt + 1'b1 : '0;
    end
  end
endmodule

// File: rtl/ballot_unit.sv
// ballot_unit: arms a ballot, accepts one clean button press and emits a fixed-length vote pulse
module ballot_unit
  import evm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int PULSE_LEN       = DEF_PULSE_LEN,
  parameter int LOCKOUT_CYCLES  = DEF_LOCKOUT_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ballot_enable,
  input  logic        btn_1,
  input  logic        btn_2,
  input  logic        btn_3,
  input  logic        i_voting_over,
  output logic        candidate_1,
  output logic        candidate_2,
  output logic        candidate_3,
  output logic        ballot_ready,
  output logic        vote_cast,
  output logic        reject,
  output logic [15:0] ballots_issued
);
  localparam int CMAX = (PULSE_LEN > LOCKOUT_CYCLES) ? PULSE_LEN : LOCKOUT_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] P_END = CW'(PULSE_LEN - 1);
  localparam logic [CW-1:0] L_END = CW'(LOCKOUT_CYCLES - 1);
  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_sel;
  logic [2:0]    r_cand;
  logic          r_ready;
  logic          r_vote;
  logic          r_reject;
  logic [15:0]   r_issued;
  logic [2:0]    w_rise;
  logic [2:0]    w_lvl;
  logic          w_single;
  logic          w_multi;
  logic          w_reject;
  logic [2:0]    w_sel_next;
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db1 (
    .clk(clk), .rst(rst), .raw(btn_1), .level(w_lvl[0]), .rise(w_rise[0])
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db2 (
    .clk(clk), .rst(rst), .raw(btn_2), .level(w_lvl[1]), .rise(w_rise[1])
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db3 (
    .clk(clk), .rst(rst), .raw(btn_3), .level(w_lvl[2]), .rise(w_rise[2])
  );
  assign w_single   = $onehot(w_rise) && ((w_lvl & ~w_rise) == 3'b000);
  assign w_multi    = (|w_rise) && !w_single;
  assign w_sel_next = (r_state == ST_ARMED && w_next == ST_EMIT) ? w_rise : r_sel;
  // Next-state and reject decision; closing the election outranks any same-cycle press
  always_comb begin
    w_next   = r_state;
    w_reject = 1'b0;
    case (r_state)
      ST_IDLE:    w_next = (ballot_enable && !i_voting_over) ? ST_ARMED : ST_IDLE;
      ST_ARMED: begin
        if (i_voting_over) w_next = ST_IDLE;
        else if (w_single) w_next = ST_EMIT;
        else w_reject = w_multi;
      end
      ST_EMIT:    w_next = (r_cnt == P_END) ? ST_LOCKOUT : ST_EMIT;
      ST_LOCKOUT: w_next = (r_cnt == L_END) ? ST_IDLE : ST_LOCKOUT;
      default:    w_next = ST_IDLE;
    endcase
  end
  // State, shared pulse/lockout counter and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_sel    <= '0;
      r_cand   <= '0;
      r_ready  <= 1'b0;
      r_vote   <= 1'b0;
      r_reject <= 1'b0;
      r_issued <= '0;
    end else begin
      r_state  <= w_next;
      r_cnt    <= (w_next != r_state) ? '0 : r_cnt + 1'b1;
      r_sel    <= w_sel_next;
      r_cand   <= (w_next == ST_EMIT) ? w_sel_next : 3'b000;
      r_ready  <= w_next == ST_ARMED;
      r_vote   <= r_state == ST_EMIT && w_next == ST_LOCKOUT;
      r_reject <= w_reject;
      r_issued <= (r_state == ST_IDLE && w_next == ST_ARMED && r_issued != 16'hFFFF) ? r_issued + 16'd1 : r_issued;
    end
  end
  assign candidate_1    = r_cand[0];
  assign candidate_2    = r_cand[1];
  assign candidate_3    = r_cand[2];
  assign ballot_ready   = r_ready;
  assign vote_cast      = r_vote;
  assign reject         = r_reject;
  assign ballots_issued = r_issued;
endmodule

// File: tb/tb_ballot_unit.sv
// tb_ballot_unit: directed stimulus with a scoreboard queue checked by a negedge monitor
module tb_ballot_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ballot_enable = 1'b0;
  logic        btn_1 = 1'b0;
  logic        btn_2 = 1'b0;
  logic        btn_3 = 1'b0;
  logic        i_voting_over = 1'b0;
  logic        candidate_1, candidate_2, candidate_3;
  logic        ballot_ready, vote_cast, reject;
  logic [15:0] ballots_issued;

  typedef struct {
    bit is_vote;
    int cand;
    int width;
    int lat;
    int issued;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int press_cyc = 0;
  int cand_pulses = 0;
  bit multi_hi = 1'b0;
  int cur_id = 0;
  int width = 0;
  int lat = 0;
  logic [2:0] prev_c = 3'b000;

  localparam int LAT = 8 + 3;

  ballot_unit dut (
    .clk(clk), .rst(rst), .ballot_enable(ballot_enable),
    .btn_1(btn_1), .btn_2(btn_2), .btn_3(btn_3), .i_voting_over(i_voting_over),
    .candidate_1(candidate_1), .candidate_2(candidate_2), .candidate_3(candidate_3),
    .ballot_ready(ballot_ready), .vote_cast(vote_cast), .reject(reject),
    .ballots_issued(ballots_issued)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: tracks candidate pulses and pops the scoreboard on every vote_cast/reject
  always @(negedge clk) begin
    logic [2:0] c;
    exp_t e;
    c = {candidate_3, candidate_2, candidate_1};
    if ($countones(c) > 1) multi_hi = 1'b1;
    if (c != 3'b000 && prev_c == 3'b000) begin
      cand_pulses++;
      cur_id = c[0] ? 1 : c[1] ? 2 : 3;
      lat = cyc - press_cyc;
      width = 0;
    end
    if (c != 3'b000) width++;
    prev_c = c;
    if (vote_cast || reject) begin
      if (sb.size() == 0) begin
        chk(vote_cast ? "unexpected_vote" : "unexpected_reject", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("event_kind_is_vote", int'(vote_cast), int'(e.is_vote));
        if (e.is_vote && vote_cast) begin
          chk("vote_cand", cur_id, e.cand);
          chk("vote_width", width, e.width);
          chk("vote_latency", lat, e.lat);
          chk("vote_issued", int'(ballots_issued), e.issued);
          chk("vote_cand_low", int'(c), 0);
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic arm();
    @(negedge clk) ballot_enable = 1'b1;
    @(negedge clk) ballot_enable = 1'b0;
  endtask

  task automatic close_ballot();
    @(negedge clk) i_voting_over = 1'b1;
    @(negedge clk) i_voting_over = 1'b0;
  endtask

  task automatic push(input bit v, input int cand, input int issued);
    exp_t e;
    e.is_vote = v;
    e.cand = cand;
    e.width = 4;
    e.lat = LAT;
    e.issued = issued;
    sb.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit seen;
    // Reset state
    cycles(3);
    chk("rst_ready", int'(ballot_ready), 0);
    chk("rst_vote", int'(vote_cast), 0);
    chk("rst_reject", int'(reject), 0);
    chk("rst_cands", int'({candidate_3, candidate_2, candidate_1}), 0);
    chk("rst_issued", int'(ballots_issued), 0);
    rst = 1'b0;
    cycles(2);
    // Single clean vote on btn_2
    arm();
    chk("arm1_ready", int'(ballot_ready), 1);
    chk("arm1_issued", int'(ballots_issued), 1);
    push(1'b1, 2, 1);
    btn_2 = 1'b1;
    press_cyc = cyc;
    cycles(30);
    btn_2 = 1'b0;
    cycles(20);
    chk("post_vote_ready", int'(ballot_ready), 0);
    // Bouncing btn_1 never debounces
    arm();
    chk("arm2_issued", int'(ballots_issued), 2);
    for (int i = 0; i < 40; i += 3) begin
      btn_1 = ~btn_1;
      cycles(3);
    end
    btn_1 = 1'b0;
    cycles(12);
    chk("bounce_ready", int'(ballot_ready), 1);
    chk("bounce_pulses", cand_pulses, 1);
    // Close voids the ballot; enable during close does not arm
    close_ballot();
    chk("close_ready", int'(ballot_ready), 0);
    @(negedge clk) begin i_voting_over = 1'b1; ballot_enable = 1'b1; end
    cycles(3);
    chk("closed_enable_issued", int'(ballots_issued), 2);
    chk("closed_enable_ready", int'(ballot_ready), 0);
    i_voting_over = 1'b0;
    ballot_enable = 1'b0;
    cycles(2);
    // btn_1 held from before arming, then btn_3 pressed: reject; later clean btn_1 vote
    btn_1 = 1'b1;
    cycles(15);
    arm();
    chk("arm3_issued", int'(ballots_issued), 3);
    push(1'b0, 0, 0);
    btn_3 = 1'b1;
    cycles(15);
    chk("reject_still_ready", int'(ballot_ready), 1);
    btn_1 = 1'b0;
    btn_3 = 1'b0;
    cycles(15);
    push(1'b1, 1, 3);
    btn_1 = 1'b1;
    press_cyc = cyc;
    cycles(15);
    btn_1 = 1'b0;
    cycles(30);
    // Simultaneous btn_1 and btn_3 rises: reject
    arm();
    chk("arm4_issued", int'(ballots_issued), 4);
    push(1'b0, 0, 0);
    btn_1 = 1'b1;
    btn_3 = 1'b1;
    cycles(15);
    btn_1 = 1'b0;
    btn_3 = 1'b0;
    cycles(15);
    chk("simul_pulses", cand_pulses, 2);
    close_ballot();
    chk("close2_ready", int'(ballot_ready), 0);
    // Reset during the second EMIT cycle
    arm();
    chk("arm5_issued", int'(ballots_issued), 5);
    btn_3 = 1'b1;
    press_cyc = cyc;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      seen = candidate_3;
    end
    chk("emit_reached", int'(seen), 1);
    @(negedge clk) rst = 1'b1;
    @(posedge clk) #1;
    chk("midrst_cands", int'({candidate_3, candidate_2, candidate_1}), 0);
    chk("midrst_vote", int'(vote_cast), 0);
    chk("midrst_ready", int'(ballot_ready), 0);
    chk("midrst_issued", int'(ballots_issued), 0);
    @(negedge clk) begin rst = 1'b0; btn_3 = 1'b0; end
    cycles(15);
    // Saturation of ballots_issued
    @(negedge clk) force dut.r_issued = 16'hFFFE;
    @(negedge clk) release dut.r_issued;
    for (int k = 0; k < 3; k++) begin
      arm();
      chk("sat_issued", int'(ballots_issued), 32'hFFFF);
      close_ballot();
    end
    cycles(10);
    chk("scoreboard_drained", sb.size(), 0);
    chk("total_cand_pulses", cand_pulses, 3);
    chk("never_two_cands", int'(multi_hi), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/ballot_unit.md
BALLOT_UNIT -- requirements
Module: ballot_unit

Interface
REQ-001 SHALL provide parameter DEBOUNCE_CYCLES, default 8: consecutive stable cycles required before a button level change is accepted.
REQ-002 SHALL provide parameter PULSE_LEN, default 4: cycles a candidate_x output is held high per vote.
REQ-003 SHALL provide parameter LOCKOUT_CYCLES, default 20 (must be >=17): post-vote dead time, covering the tally stage's 16-cycle check interval.
REQ-004 Ports, in this order:
- clk  in  1  sole clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ballot_enable  in  1  presiding-officer arm request, level-sampled.
- btn_1 / btn_2 / btn_3  in  1 each  raw asynchronous voter buttons, active-high.
- i_voting_over  in  1  election-closed level, shared with the tally stage.
- candidate_1 / candidate_2 / candidate_3  out  1 each  vote pulses to the tally stage, which counts the falling edge.
- ballot_ready  out  1  high while a ballot is armed.
- vote_cast  out  1  one-cycle pulse when a vote completes.
- reject  out  1  one-cycle pulse on a multi-button press.
- ballots_issued  out  16  count of ballots armed.

Function
REQ-005 Each btn_x SHALL pass through a 2-flop synchronizer and then a debouncer.
REQ-006 The debounced level SHALL change only after the synchronized input has differed from it for DEBOUNCE_CYCLES consecutive cycles.
REQ-007 The debouncer's rise output SHALL pulse for one cycle, in the same cycle the debounced level goes high.
REQ-008 The FSM SHALL have four states: IDLE, ARMED, EMIT, LOCKOUT.
REQ-009 IDLE: ballot_ready=0; if ballot_enable=1 and i_voting_over=0, go to ARMED next cycle and increment ballots_issued, saturating at 16'hFFFF.
REQ-010 ARMED: ballot_ready=1; ballot_enable is ignored.
REQ-011 ARMED, valid press: a rise pulse on exactly one button while the other two debounced levels are low SHALL latch that candidate and go to EMIT.
REQ-012 ARMED, multi-press: a rise pulse while any other debounced level is high, or simultaneous rise pulses, SHALL assert reject for one cycle; state stays ARMED and no candidate is latched.
REQ-013 ARMED, close: i_voting_over=1 SHALL return the FSM to IDLE, voiding the ballot with no candidate pulse; this takes priority over a same-cycle press.
REQ-014 EMIT timing: if the rise is sampled in cycle t, the latched candidate_x SHALL be high in cycles t+1 through t+PULSE_LEN and low from t+PULSE_LEN+1.
REQ-015 EMIT exit: in cycle t+PULSE_LEN+1, vote_cast SHALL be 1 for that one cycle and the state SHALL be LOCKOUT.
REQ-016 i_voting_over asserting during EMIT SHALL NOT truncate the pulse; a committed vote always completes.
REQ-017 At most one candidate_x SHALL be high in any cycle; all three SHALL be 0 outside EMIT.
REQ-018 LOCKOUT: ignore buttons and ballot_enable for LOCKOUT_CYCLES cycles, then go to IDLE.
REQ-019 A button still held on re-arm SHALL NOT vote until it is released (debounced low) and pressed again, since only rise pulses are accepted.
REQ-020 ballot_enable held high continuously SHALL arm exactly one ballot per IDLE visit.
REQ-021 All outputs SHALL be registered.

Reset
REQ-022 rst=1 SHALL force, at the next clock edge: state IDLE; candidate_1..3=0; ballot_ready=0; vote_cast=0; reject=0; ballots_issued=0.
REQ-023 rst=1 SHALL also clear the synchronizers, the debounced levels and the debounce counters, the pulse and lockout counters, and the latched candidate.
REQ-024 Reset mid-EMIT SHALL drop candidate_x low the next cycle with no vote_cast; that falling edge is the tally stage's concern, since it shares rst.

Structure
REQ-025 The state encoding and the default parameter values SHALL reside in the shared package evm_pkg.
REQ-026 The synchronizer plus debouncer SHALL be a sub-module btn_debounce (ports clk, rst, raw, level, rise), instantiated three times.

Verification
REQ-027 Arm, then btn_2 held 30 cycles -> candidate_2 high exactly 4 cycles starting 1 cycle after rise; vote_cast 1 cycle; ballots_issued=1; candidate_1 and candidate_3 stay 0.
REQ-028 btn_1 toggling every 3 cycles for 40 cycles while ARMED -> no rise, no candidate pulse, ballot_ready stays 1.
REQ-029 btn_1 held, then btn_3 pressed while ARMED -> one cycle of reject with btn_1's single vote only if btn_1's rise came first alone; simultaneous btn_1 and btn_3 rises -> reject=1, no candidate pulse.
REQ-030 Armed, then i_voting_over=1 -> IDLE, ballot_ready=0, no candidate pulse; ballot_enable while i_voting_over=1 -> ballots_issued unchanged.
REQ-031 rst=1 in the 2nd EMIT cycle -> all outputs 0 next cycle, state IDLE, ballots_issued=0.
REQ-032 ballots_issued preloaded near 16'hFFFE, arm 3 times -> reads 16'hFFFF with no wrap.
